// File: rtl/ecc_apb_master.sv
// ecc_apb_master: programs an ECC block over APB, waits for operation_done, and reports the result.
// Build macro ECC_APB_MASTER_READBACK_EN adds a DATA_IN readback between the NOISE and CTRL writes.
module ecc_apb_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [AMBA_WORD-1:0]       cmd_ctrl,
    input  logic [AMBA_WORD-1:0]       cmd_data,
    input  logic [AMBA_WORD-1:0]       cmd_cw_width,
    input  logic [AMBA_WORD-1:0]       cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       res_valid,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_errors,
    output logic                       res_timeout,
    output logic                       res_rb_err
);
    localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_ACCESS = 3'd2, S_WAIT = 3'd3, S_RESP = 3'd4;
    localparam logic [2:0] ST_DATA = 3'd0, ST_CW = 3'd1, ST_NOISE = 3'd2, ST_READ = 3'd3, ST_CTRL = 3'd4;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]            state_q, state_d, step_q, step_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [AMBA_WORD-1:0]  ctrl_q, ctrl_d, data_q, data_d, cw_q, cw_d, noise_q, noise_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [1:0]            res_errors_q, res_errors_d;
    logic                  res_timeout_q, res_timeout_d, rb_err_q, rb_err_d, xfer;

    assign xfer        = state_q == S_SETUP || state_q == S_ACCESS;
    assign cmd_ready   = state_q == S_IDLE;
    assign PSEL        = xfer;
    assign PENABLE     = state_q == S_ACCESS;
    assign PWRITE      = xfer && step_q != ST_READ;
    assign PADDR       = !xfer ? '0 :
                         (step_q == ST_DATA || step_q == ST_READ) ? AMBA_ADDR_WIDTH'(4) :
                         step_q == ST_CW ? AMBA_ADDR_WIDTH'(8) :
                         step_q == ST_NOISE ? AMBA_ADDR_WIDTH'(12) : '0;
    assign PWDATA      = !PWRITE ? '0 :
                         step_q == ST_DATA ? data_q :
                         step_q == ST_CW ? cw_q :
                         step_q == ST_NOISE ? noise_q : ctrl_q;
    assign res_valid   = state_q == S_RESP;
    assign res_data    = res_data_q;
    assign res_errors  = res_errors_q;
    assign res_timeout = res_timeout_q;
    assign res_rb_err  = rb_err_q;

`ifndef ECC_APB_MASTER_READBACK_EN
    logic unused_prdata;
    assign unused_prdata = ^PRDATA;
`endif

    // next-state: command latch, register-write sequencing, completion wait and result capture
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        cnt_d         = cnt_q;
        ctrl_d        = ctrl_q;
        data_d        = data_q;
        cw_d          = cw_q;
        noise_d       = noise_q;
        res_data_d    = res_data_q;
        res_errors_d  = res_errors_q;
        res_timeout_d = res_timeout_q;
        rb_err_d      = rb_err_q;
        unique case (state_q)
            S_IDLE: if (cmd_valid) begin
                ctrl_d        = cmd_ctrl;
                data_d        = cmd_data;
                cw_d          = cmd_cw_width;
                noise_d       = cmd_noise;
                res_timeout_d = 1'b0;
                rb_err_d      = 1'b0;
                step_d        = ST_DATA;
                state_d       = S_SETUP;
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
`ifdef ECC_APB_MASTER_READBACK_EN
                if (step_q == ST_READ && PRDATA != data_q) rb_err_d = 1'b1;
                step_d = step_q == ST_NOISE ? ST_READ : step_q + 3'd1;
`else
                step_d = step_q == ST_NOISE ? ST_CTRL : step_q + 3'd1;
`endif
                cnt_d   = '0;
                state_d = step_q == ST_CTRL ? S_WAIT : S_SETUP;
            end
            S_WAIT: if (operation_done) begin
                res_data_d    = data_out;
                res_errors_d  = num_of_errors;
                res_timeout_d = 1'b0;
                state_d       = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                res_data_d    = '0;
                res_errors_d  = '0;
                res_timeout_d = 1'b1;
                state_d       = S_RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            step_q        <= ST_DATA;
            cnt_q         <= '0;
            ctrl_q        <= '0;
            data_q        <= '0;
            cw_q          <= '0;
            noise_q       <= '0;
            res_data_q    <= '0;
            res_errors_q  <= '0;
            res_timeout_q <= 1'b0;
            rb_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            ctrl_q        <= ctrl_d;
            data_q        <= data_d;
            cw_q          <= cw_d;
            noise_q       <= noise_d;
            res_data_q    <= res_data_d;
            res_errors_q  <= res_errors_d;
            res_timeout_q <= res_timeout_d;
            rb_err_q      <= rb_err_d;
        end
    end
endmodule

// File: tb/tb_ecc_apb_master.sv
// tb_ecc_apb_master: directed bench for ecc_apb_master (honours ECC_APB_MASTER_READBACK_EN).
module tb_ecc_apb_master;
`ifdef ECC_APB_MASTER_READBACK_EN
    localparam int NS = 5;
`else
    localparam int NS = 4;
`endif
    localparam int WD = 1 + 2 * NS;

    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_ctrl = '0, cmd_data = '0, cmd_cw_width = '0, cmd_noise = '0;
    logic [19:0] PADDR;
    logic [31:0] PWDATA, PRDATA = '0;
    logic        PSEL, PENABLE, PWRITE, operation_done = 1'b0;
    logic [31:0] data_out = '0, res_data;
    logic [1:0]  num_of_errors = '0, res_errors;
    logic        res_valid, res_timeout, res_rb_err;
    int          total = 0, bad = 0;
    bit          seen_res, seen_ctrl;

    ecc_apb_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ctrl(cmd_ctrl), .cmd_data(cmd_data), .cmd_cw_width(cmd_cw_width), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRDATA(PRDATA), .operation_done(operation_done), .data_out(data_out),
        .num_of_errors(num_of_errors), .res_valid(res_valid), .res_data(res_data),
        .res_errors(res_errors), .res_timeout(res_timeout), .res_rb_err(res_rb_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Drives a command in cycle 0 and checks every APB cycle; returns in the first WAIT_DONE cycle.
    task automatic issue(input logic [31:0] c, d, w, n, input bit hold);
        logic [19:0] ea;
        logic [31:0] ew;
        logic        wr;
        cmd_ctrl = c; cmd_data = d; cmd_cw_width = w; cmd_noise = n; cmd_valid = 1'b1;
        chk("accept_ready", cmd_ready, 1);
        tick;
        if (!hold) cmd_valid = 1'b0;
        for (int s = 0; s < NS; s++) begin
            wr = 1'b1;
            if (s == NS - 1) begin ea = 20'h0; ew = c; end
            else if (s == 0) begin ea = 20'h4; ew = d; end
            else if (s == 1) begin ea = 20'h8; ew = w; end
            else if (s == 2) begin ea = 20'hC; ew = n; end
            else begin ea = 20'h4; ew = 0; wr = 1'b0; end
            for (int p = 0; p < 2; p++) begin
                chk("psel", PSEL, 1);
                chk("penable", PENABLE, p);
                chk("paddr", PADDR, ea);
                chk("pwrite", PWRITE, wr);
                if (wr) chk("pwdata", PWDATA, ew);
                chk("busy_ready", cmd_ready, 0);
                tick;
            end
        end
        chk("wait_psel", PSEL, 0);
        chk("wait_penable", PENABLE, 0);
        chk("wait_paddr", PADDR, 0);
        chk("wait_ready", cmd_ready, 0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_timeout", res_timeout, 0);
        chk("rst_rberr", res_rb_err, 0);
        rst = 1'b0;
        tick;

        // nominal command; a stray operation_done during the writes must be ignored
        PRDATA = 32'hA5;
        fork
            begin tick; tick; operation_done = 1'b1; data_out = 32'h33; tick; operation_done = 1'b0; end
        join_none
        issue(32'h0, 32'hA5, 32'h0, 32'h0, 1'b0);
        chk("a_rb", res_rb_err, 0);
        tick;
        tick;
        operation_done = 1'b1; data_out = 32'hA5; num_of_errors = 2'd0;
        tick;
        operation_done = 1'b0; data_out = 32'hFF;
        chk("a_valid", res_valid, 1);
        chk("a_data", res_data, 32'hA5);
        chk("a_errors", res_errors, 0);
        chk("a_timeout", res_timeout, 0);
        chk("a_resp_ready", cmd_ready, 0);
        tick;
        chk("a_valid_drop", res_valid, 0);
        chk("a_ready_back", cmd_ready, 1);
        chk("a_data_hold", res_data, 32'hA5);

        // timeout: operation_done never arrives
        issue(32'h1, 32'h1234, 32'h20, 32'h3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("b_wait_valid", res_valid, 0);
            tick;
        end
        chk("b_terminal_valid", res_valid, 0);
        tick;
        chk("b_valid", res_valid, 1);
        chk("b_timeout", res_timeout, 1);
        chk("b_data", res_data, 0);
        chk("b_errors", res_errors, 0);
        tick;
        chk("b_valid_drop", res_valid, 0);
        chk("b_timeout_hold", res_timeout, 1);

        // operation_done exactly at the terminal count counts as done
        issue(32'h1, 32'h55, 32'h20, 32'h1, 1'b0);
        chk("c_timeout_cleared", res_timeout, 0);
        for (int i = 0; i < 16; i++) tick;
        operation_done = 1'b1; data_out = 32'h5A5A; num_of_errors = 2'd2;
        tick;
        operation_done = 1'b0;
        chk("c_valid", res_valid, 1);
        chk("c_timeout", res_timeout, 0);
        chk("c_data", res_data, 32'h5A5A);
        chk("c_errors", res_errors, 2);
        tick;

        // reset asserted in cycle 4, before CTRL is written
        cmd_ctrl = 32'h1; cmd_data = 32'h9; cmd_cw_width = 32'h0; cmd_noise = 32'h0; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        tick;
        chk("d_c4_psel", PSEL, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("d_psel", PSEL, 0);
        chk("d_penable", PENABLE, 0);
        chk("d_ready", cmd_ready, 1);
        seen_res = 1'b0; seen_ctrl = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (res_valid) seen_res = 1'b1;
            if (PSEL && PADDR == 20'h0) seen_ctrl = 1'b1;
            tick;
        end
        chk("d_no_res", seen_res, 0);
        chk("d_no_ctrl", seen_ctrl, 0);

        // cmd_valid held high: the next command is taken only after RESP
        issue(32'h1, 32'h66, 32'h8, 32'h2, 1'b1);
        tick;
        tick;
        operation_done = 1'b1; data_out = 32'h66;
        tick;
        operation_done = 1'b0;
        cmd_data = 32'h77;
        chk("e_valid", res_valid, 1);
        chk("e_resp_ready", cmd_ready, 0);
        chk("e_resp_psel", PSEL, 0);
        tick;
        chk("e_idle_ready", cmd_ready, 1);
        chk("e_idle_psel", PSEL, 0);
        tick;
        cmd_valid = 1'b0;
        chk("e_next_psel", PSEL, 1);
        chk("e_next_penable", PENABLE, 0);
        chk("e_next_paddr", PADDR, 20'h4);
        chk("e_next_pwdata", PWDATA, 32'h77);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;

`ifdef ECC_APB_MASTER_READBACK_EN
        // readback mismatch still leads to the CTRL write and a normal result
        PRDATA = 32'hA4;
        issue(32'h0, 32'hA5, 32'h0, 32'h0, 1'b0);
        chk("f_rb_err", res_rb_err, 1);
        operation_done = 1'b1; data_out = 32'hA5;
        tick;
        operation_done = 1'b0;
        chk("f_valid", res_valid, 1);
        chk("f_rb_hold", res_rb_err, 1);
        tick;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
